escrever_instrucao: RTL and testbench
=====================================

Name: escrever_instrucao

Overview:
Byte-serial program loader that fills the instruction memory before execution. It accepts a stream of bytes over a valid/ready handshake and assembles them little-endian into 32-bit instruction words. It writes each word into the instruction memory through a single write port, at consecutive word indices starting at 0. It is the write side of the fetch path and replaces file preloading when a program is delivered at run time.

Parameters:
NUM_INSTR, 12, number of instruction words to load; word indices 0..NUM_INSTR-1.
ADDR_W, 32, width of the word-index address output; matches PC width.

Ports:
clk  input  1  system clock, rising-edge active
reset  input  1  asynchronous, active-high reset
iniciar  input  1  start pulse; begins a load from index 0
abortar  input  1  cancel the current load; return to idle without a write
byte_in  input  8  incoming program byte
byte_valido  input  1  byte_in holds a valid byte
byte_pronto  output  1  loader can accept a byte this cycle
mem_we  output  1  instruction-memory write enable, one cycle per word
mem_addr  output  ADDR_W  word index being written (word index, not byte address)
mem_dado  output  32  assembled instruction word
ocupado  output  1  load in progress (RECEBE or ESCREVE)
concluido  output  1  all NUM_INSTR words written

Behaviour:
- FSM states: IDLE, RECEBE, ESCREVE, FIM. All state, counters and outputs are registered, or decoded only from state registers.
- Reset (asynchronous, any state): state=IDLE; byte_cnt=0; mem_addr=0; mem_dado=0; mem_we=0; byte_pronto=0; ocupado=0; concluido=0.
- IDLE:
  - byte_pronto=0, ocupado=0.
  - iniciar=1 -> RECEBE; mem_addr=0, byte_cnt=0, concluido=0.
- RECEBE:
  - byte_pronto=1, ocupado=1.
  - A byte transfers on a rising edge where byte_valido=1 and byte_pronto=1. byte_in is stored at mem_dado[8*byte_cnt+7 : 8*byte_cnt], then byte_cnt increments (2-bit).
  - When the transfer has byte_cnt=3 -> ESCREVE; byte_cnt wraps to 0.
  - byte_valido=0 holds state; no timeout.
- ESCREVE:
  - Lasts exactly one cycle. mem_we=1, byte_pronto=0, ocupado=1.
  - mem_addr and mem_dado are stable for the whole cycle; memory samples on the edge that ends the cycle.
  - Next state: if mem_addr==NUM_INSTR-1 -> FIM, mem_addr holds. Otherwise mem_addr+1 -> RECEBE.
- FIM:
  - concluido=1, ocupado=0, byte_pronto=0.
  - Held until iniciar=1, which restarts exactly as from IDLE.
- Latency: the 4th byte is accepted at edge k; mem_we is high between edges k and k+1. Minimum 5 cycles per word.
- iniciar is ignored in RECEBE and ESCREVE.
- abortar=1 in RECEBE or ESCREVE -> IDLE at the next edge. No mem_we is issued in the following cycle; partial word discarded; byte_cnt=0; concluido stays 0. If abortar falls in the ESCREVE cycle, that one write still occurs (mem_we is already high).
- abortar has priority over iniciar and byte transfer. In IDLE and FIM, abortar -> IDLE and clears concluido.
- mem_we is never high in any state other than ESCREVE.
- mem_dado keeps the last written word after FIM.

Test Plan:
- Reset, then iniciar. Send bytes 0x13,0x05,0x50,0x00 with byte_valido held high -> one mem_we pulse with mem_addr=0, mem_dado=0x00500513, on the cycle after the 4th byte. byte_pronto=0 in that cycle.
- Full load of 12 words, word i = 0xA0000000+i -> 12 mem_we pulses at addr 0..11 with matching data. Then concluido=1, ocupado=0, byte_pronto=0, and no 13th write when more bytes are offered.
- byte_valido toggled randomly with gaps of 0-3 cycles -> same words and addresses as the gapless case. No byte lost or duplicated.
- Asynchronous reset asserted mid-cycle after 2 bytes of word 5 -> all outputs 0 immediately, before the next edge. A new load then starts at addr 0.
- abortar after 3 bytes of word 2 -> no write at addr 2, IDLE. A subsequent iniciar writes its first word to addr 0, and byte ordering is correct (no stale bytes).
- iniciar pulsed during RECEBE -> ignored, addresses continue. iniciar in FIM -> concluido=0, reload from addr 0.

Source files
------------

// File: rtl/escrever_instrucao.sv
// escrever_instrucao: byte-serial program loader for the instruction memory.
// Bytes arrive over a valid/ready handshake, are packed little-endian into
// 32-bit words and written at consecutive word indices 0..NUM_INSTR-1.
module escrever_instrucao #(
    parameter int NUM_INSTR = 12,
    parameter int ADDR_W    = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              iniciar,
    input  logic              abortar,
    input  logic [7:0]        byte_in,
    input  logic              byte_valido,
    output logic              byte_pronto,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_dado,
    output logic              ocupado,
    output logic              concluido
);

    typedef enum logic [1:0] {
        IDLE,
        RECEBE,
        ESCREVE,
        FIM
    } state_t;

    state_t     state;
    state_t     state_next;
    logic [1:0] byte_cnt;
    logic       last_word;

    assign last_word = (mem_addr == ADDR_W'(NUM_INSTR - 1));

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; all handshake/status outputs decode from state only
    always_comb begin
        state_next  = state;
        byte_pronto = 1'b0;
        ocupado     = 1'b0;
        mem_we      = 1'b0;
        concluido   = 1'b0;
        case (state)
            IDLE: begin
                if (abortar)      state_next = IDLE;
                else if (iniciar) state_next = RECEBE;
            end
            RECEBE: begin
                byte_pronto = 1'b1;
                ocupado     = 1'b1;
                if (abortar)                           state_next = IDLE;
                else if (byte_valido && byte_cnt == 2'd3) state_next = ESCREVE;
            end
            ESCREVE: begin
                mem_we  = 1'b1;
                ocupado = 1'b1;
                if (abortar)        state_next = IDLE;
                else if (last_word) state_next = FIM;
                else                state_next = RECEBE;
            end
            FIM: begin
                concluido = 1'b1;
                if (abortar)      state_next = IDLE;
                else if (iniciar) state_next = RECEBE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Datapath: byte counter, word assembly and word index
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            byte_cnt <= '0;
            mem_addr <= '0;
            mem_dado <= '0;
        end else if (abortar) begin
            // partial word is dropped; mem_addr is reloaded by the next start
            byte_cnt <= '0;
        end else begin
            case (state)
                IDLE, FIM: begin
                    if (iniciar) begin
                        byte_cnt <= '0;
                        mem_addr <= '0;
                    end
                end
                RECEBE: begin
                    if (byte_valido) begin
                        mem_dado[{byte_cnt, 3'b000} +: 8] <= byte_in;
                        byte_cnt <= byte_cnt + 2'd1;
                    end
                end
                ESCREVE: begin
                    if (!last_word) mem_addr <= mem_addr + ADDR_W'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_escrever_instrucao.sv
// Testbench for escrever_instrucao: directed scenarios with random data and gaps,
// checked against a queue of expected (address, word) writes.
module tb_escrever_instrucao;

    localparam int NUM_INSTR = 12;
    localparam int ADDR_W    = 32;

    logic              clk = 1'b0;
    logic              reset;
    logic              iniciar;
    logic              abortar;
    logic [7:0]        byte_in;
    logic              byte_valido;
    logic              byte_pronto;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_dado;
    logic              ocupado;
    logic              concluido;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t exp_q[$];
    logic [31:0] words[NUM_INSTR];

    escrever_instrucao #(.NUM_INSTR(NUM_INSTR), .ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .iniciar    (iniciar),
        .abortar    (abortar),
        .byte_in    (byte_in),
        .byte_valido(byte_valido),
        .byte_pronto(byte_pronto),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_dado   (mem_dado),
        .ocupado    (ocupado),
        .concluido  (concluido)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    // One clock, then observe just after the edge; every write is matched to the model
    task automatic step();
        wr_t e;
        @(posedge clk);
        #1;
        if (mem_we === 1'b1) begin
            check("write_expected", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("write_addr", 64'(mem_addr), 64'(e.addr));
                check("write_data", 64'(mem_dado), 64'(e.data));
                check("write_pronto_low", 64'(byte_pronto), 64'd0);
            end
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n;
        byte_in     = b;
        byte_valido = 1'b1;
        n = 0;
        while (byte_pronto !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        check("byte_pronto_wait", 64'(byte_pronto), 64'd1);
        step();
    endtask

    // Send one word little-endian; optional random idle gaps and stray iniciar pulses
    task automatic send_word(input logic [31:0] w, input int gapmax, input bit poke);
        logic [31:0] tmp;
        tmp = w;
        for (int k = 0; k < 4; k++) begin
            if (poke && k == 1) iniciar = 1'b1;
            send_byte(tmp[8*k +: 8]);
            iniciar = 1'b0;
            if (gapmax > 0) begin
                byte_valido = 1'b0;
                repeat ($urandom_range(0, gapmax)) step();
            end
        end
    endtask

    task automatic start_load();
        iniciar = 1'b1;
        step();
        iniciar = 1'b0;
    endtask

    task automatic expect_write(input int idx, input logic [31:0] w);
        wr_t e;
        e.addr = 32'(idx);
        e.data = w;
        exp_q.push_back(e);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; iniciar = 1'b0; abortar = 1'b0; byte_in = '0; byte_valido = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_we", 64'(mem_we), 64'd0);
        check("rst_addr", 64'(mem_addr), 64'd0);
        check("rst_dado", 64'(mem_dado), 64'd0);
        check("rst_pronto", 64'(byte_pronto), 64'd0);
        check("rst_ocupado", 64'(ocupado), 64'd0);
        check("rst_concluido", 64'(concluido), 64'd0);
        reset = 1'b0;
        step();
        check("idle_pronto", 64'(byte_pronto), 64'd0);

        // First word of the reference program
        start_load();
        check("recebe_pronto", 64'(byte_pronto), 64'd1);
        check("recebe_ocupado", 64'(ocupado), 64'd1);
        expect_write(0, 32'h00500513);
        send_word(32'h00500513, 0, 1'b0);
        check("first_word_done", 64'(exp_q.size()), 64'd0);
        byte_valido = 1'b0;
        step();
        abortar = 1'b1;
        step();
        abortar = 1'b0;
        check("abort_idle_ocupado", 64'(ocupado), 64'd0);
        check("abort_idle_pronto", 64'(byte_pronto), 64'd0);

        // Full gapless load
        start_load();
        for (int i = 0; i < NUM_INSTR; i++) begin
            words[i] = 32'hA000_0000 + 32'(i);
            expect_write(i, words[i]);
            send_word(words[i], 0, 1'b0);
        end
        step();
        check("full_concluido", 64'(concluido), 64'd1);
        check("full_ocupado", 64'(ocupado), 64'd0);
        check("full_pronto", 64'(byte_pronto), 64'd0);
        byte_in = 8'h5A;
        byte_valido = 1'b1;
        repeat (8) step();
        byte_valido = 1'b0;
        check("full_all_written", 64'(exp_q.size()), 64'd0);
        check("fim_dado_held", 64'(mem_dado), 64'(words[NUM_INSTR-1]));

        // Restart from FIM with random words, random gaps and ignored iniciar pulses
        start_load();
        check("restart_concluido", 64'(concluido), 64'd0);
        check("restart_ocupado", 64'(ocupado), 64'd1);
        for (int i = 0; i < NUM_INSTR; i++) begin
            words[i] = $urandom();
            expect_write(i, words[i]);
            send_word(words[i], 3, ($urandom_range(0, 1) == 1));
        end
        byte_valido = 1'b0;
        step();
        check("rand_concluido", 64'(concluido), 64'd1);
        check("rand_all_written", 64'(exp_q.size()), 64'd0);
        check("rand_dado_held", 64'(mem_dado), 64'(words[NUM_INSTR-1]));

        // Asynchronous reset in the middle of word 5
        start_load();
        for (int i = 0; i < 5; i++) begin
            words[i] = $urandom();
            expect_write(i, words[i]);
            send_word(words[i], 1, 1'b0);
        end
        send_byte(8'hDE);
        send_byte(8'hAD);
        byte_valido = 1'b0;
        check("pre_reset_writes", 64'(exp_q.size()), 64'd0);
        #3 reset = 1'b1;
        #1;
        check("arst_we", 64'(mem_we), 64'd0);
        check("arst_addr", 64'(mem_addr), 64'd0);
        check("arst_dado", 64'(mem_dado), 64'd0);
        check("arst_pronto", 64'(byte_pronto), 64'd0);
        check("arst_ocupado", 64'(ocupado), 64'd0);
        check("arst_concluido", 64'(concluido), 64'd0);
        #1 reset = 1'b0;
        start_load();
        words[0] = $urandom();
        expect_write(0, words[0]);
        send_word(words[0], 2, 1'b0);
        check("post_reset_written", 64'(exp_q.size()), 64'd0);

        // Abort after 3 bytes of word 2: no write, then a clean reload from 0
        byte_valido = 1'b0;
        abortar = 1'b1;
        step();
        abortar = 1'b0;
        start_load();
        for (int i = 0; i < 2; i++) begin
            words[i] = $urandom();
            expect_write(i, words[i]);
            send_word(words[i], 1, 1'b0);
        end
        send_byte(8'hAA);
        send_byte(8'hBB);
        send_byte(8'hCC);
        byte_valido = 1'b0;
        abortar = 1'b1;
        step();
        abortar = 1'b0;
        repeat (3) step();
        check("abort_no_write", 64'(exp_q.size()), 64'd0);
        check("abort_ocupado", 64'(ocupado), 64'd0);
        check("abort_concluido", 64'(concluido), 64'd0);
        start_load();
        expect_write(0, 32'h1122_3344);
        send_word(32'h1122_3344, 0, 1'b0);
        byte_valido = 1'b0;
        step();
        check("reload_written", 64'(exp_q.size()), 64'd0);
        check("reload_next_addr", 64'(mem_addr), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
